primogen_buf: RTL and testbench
===============================

Name: primogen_buf

Overview:
- Downstream consumer of the primogen prime generator.
- Sequences primogen's go/ready handshake and captures each prime, starting with the value presented after reset.
- Buffers captured primes in a small FIFO and offers them on a valid/ready stream to later stages.
- Reports generator errors and handshake timeouts as a sticky error. Can stop after a programmable number of primes.

Parameters:
WIDTH, 16, data width; matches primogen res.
DEPTH, 4, FIFO entries; power of 2, minimum 2.
LIMIT, 0, number of primes to deliver before stopping; 0 means unlimited.
TIMEOUT, 64, maximum cycles to wait for gen_ready to fall after a go pulse.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset; shared with primogen.
en  in  1  permits requesting further primes.
gen_go  out  1  go pulse to primogen.
gen_ready  in  1  primogen ready.
gen_error  in  1  primogen error.
gen_res  in  WIDTH  primogen result.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accepts the head entry.
out_data  out  WIDTH  FIFO head entry.
full  out  1  FIFO full.
err  out  1  sticky error.
done  out  1  LIMIT primes have been delivered to the FIFO.
count  out  16  primes pushed since reset.

Behaviour:
- Reset (rst=0, asynchronous): gen_go=0, out_valid=0, out_data=0, full=0, err=0, done=0, count=0. FIFO is emptied and FSM goes to S_INIT. Reset may occur in any state; the cycle in progress is abandoned.
- S_INIT: wait for gen_ready=1.
  - gen_error=1 -> S_ERR.
  - otherwise -> S_CAPT.
  - No go is issued; the post-reset value of res (1) is captured.
- S_CAPT: if the FIFO is not full, push gen_res, increment count, then -> S_IDLE. If full, stall in S_CAPT.
- S_IDLE:
  - if LIMIT!=0 and count==LIMIT: set done=1 and stay in S_IDLE permanently.
  - else if en=1 and the FIFO is not full -> S_GO.
- S_GO: gen_go=1 for exactly one cycle (registered output) -> S_WBUSY.
- S_WBUSY: wait for gen_ready=0, then -> S_WDONE.
  - A cycle counter starts at S_WBUSY entry.
  - If TIMEOUT cycles elapse with gen_ready still 1 -> S_ERR.
- S_WDONE: wait for gen_ready=1 (no timeout).
  - gen_error=1 at that time -> S_ERR.
  - otherwise -> S_CAPT.
- S_ERR: err=1 and gen_go=0 until reset. The FIFO keeps draining normally.
- FIFO rules:
  - push occurs only when not full, evaluated before any same-cycle pop;
  - pop occurs when out_valid && out_ready;
  - simultaneous push and pop when not full: occupancy is unchanged;
  - pop when empty is ignored.
- Latency:
  - S_CAPT edge -> out_valid/out_data visible the next cycle;
  - go -> capture is gen latency + 2 cycles (S_WDONE detect, S_CAPT push).
- Wrap-around: FIFO pointers are log2(DEPTH) bits plus a wrap bit. count saturates at 16'hFFFF.
- gen_res is sampled only in S_CAPT; changes at other times are ignored.

Decomposition:
- primogen_pkg: WIDTH default constant, FSM state enum (S_INIT, S_CAPT, S_IDLE, S_GO, S_WBUSY, S_WDONE, S_ERR), timeout counter width.
- Sub-module prime_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/head, same clk/rst.

Test Plan:
1. Reset, en=1, out_ready=1, behavioural primogen model -> out_data sequence 1,2,3,5,7,11,13,17,19,23,29,31,37; err=0; one gen_go pulse per prime after the first.
2. DEPTH=4, out_ready=0 -> FIFO holds 1,2,3,5, full=1, exactly 3 go pulses, then no further go. Raise out_ready -> drains 1,2,3,5 in order, resumes with 7,11.
3. Model asserts gen_error with ready on the 5th prime -> err=1 sticky; 1,2,3,5 still drain; no push of the 5th value; gen_go stays 0.
4. Model ignores go (ready held 1), TIMEOUT=64 -> err=1 exactly 64 cycles after S_WBUSY entry.
5. LIMIT=5 -> exactly 1,2,3,5,7 delivered, done=1, count=5, no 6th go.
6. rst=0 asserted in S_WDONE mid-request -> all outputs go to reset values immediately (asynchronously). After release, the FIFO is empty and the first push is the generator's post-reset value 1.

Source files
------------

// File: rtl/primogen_pkg.sv
// primogen_pkg: shared definitions for the primogen consumer slice.
//   PG_WIDTH   - default result width of the primogen generator
//   TMO_W      - width of the handshake timeout counter
//   pg_state_t - sequencing FSM states of primogen_buf
//   sat_inc16  - saturating increment for the 16-bit prime counter
package primogen_pkg;

  localparam int unsigned PG_WIDTH = 16;
  localparam int unsigned TMO_W    = 16;

  typedef enum logic [2:0] {
    S_INIT,
    S_CAPT,
    S_IDLE,
    S_GO,
    S_WBUSY,
    S_WDONE,
    S_ERR
  } pg_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prime_fifo.sv
// prime_fifo: synchronous FIFO holding captured primes.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, empties the FIFO
//   push  - write din (ignored when full; fullness is taken before any pop)
//   din   - data to write
//   pop   - remove head entry (ignored when empty)
//   full  - DEPTH entries held
//   empty - no entries held
//   head  - oldest entry
module prime_fifo
  import primogen_pkg::*;
#(
  parameter int unsigned WIDTH = PG_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/primogen_buf.sv
// primogen_buf: sequences the primogen go/ready handshake, captures each
// prime (starting with the post-reset value), buffers it in prime_fifo and
// offers it on a valid/ready stream.
//   clk, rst          - clock; asynchronous active-low reset (shared with primogen)
//   en                - permits requesting further primes
//   gen_go            - registered one-cycle go pulse to primogen
//   gen_ready/error/res - primogen status and result
//   out_valid/ready/data - downstream stream (FIFO head)
//   full              - FIFO full
//   err               - sticky generator error or handshake timeout
//   done              - LIMIT primes pushed (never set when LIMIT is 0)
//   count             - primes pushed since reset, saturating
module primogen_buf
  import primogen_pkg::*;
#(
  parameter int unsigned WIDTH   = PG_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LIMIT   = 0,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             gen_go,
  input  logic             gen_ready,
  input  logic             gen_error,
  input  logic [WIDTH-1:0] gen_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             err,
  output logic             done,
  output logic [15:0]      count
);

  localparam logic [15:0]      LIMIT_CNT = 16'(LIMIT);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  pg_state_t        r_state;
  pg_state_t        w_next;
  logic [TMO_W-1:0] r_tmo;
  logic             r_go;
  logic             r_err;
  logic             r_done;
  logic [15:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_limit_hit;
  logic             w_tmo_hit;

  assign w_push      = (r_state == S_CAPT) && !w_full;
  assign w_limit_hit = (LIMIT != 0) && (r_count == LIMIT_CNT);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (gen_ready) w_next = gen_error ? S_ERR : S_CAPT;
      S_CAPT:  if (!w_full) w_next = S_IDLE;
      S_IDLE:  if (!w_limit_hit && en && !w_full) w_next = S_GO;
      S_GO:    w_next = S_WBUSY;
      S_WBUSY: begin
        if (!gen_ready)     w_next = S_WDONE;
        else if (w_tmo_hit) w_next = S_ERR;
      end
      S_WDONE: if (gen_ready) w_next = gen_error ? S_ERR : S_CAPT;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_go    <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      // go is high exactly while the FSM sits in S_GO.
      r_go    <= (w_next == S_GO);
      r_err   <= r_err | (w_next == S_ERR);
      if ((r_state == S_IDLE) && w_limit_hit) begin
        r_done <= 1'b1;
      end
      if (w_push) begin
        r_count <= sat_inc16(r_count);
      end
      // Counter is zero on S_WBUSY entry and counts each waiting cycle.
      if (r_state != S_WBUSY) begin
        r_tmo <= '0;
      end else if (gen_ready && !w_tmo_hit) begin
        r_tmo <= r_tmo + TMO_ONE;
      end
    end
  end

  prime_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (gen_res),
    .pop   (out_valid && out_ready),
    .full  (w_full),
    .empty (w_empty),
    .head  (out_data)
  );

  assign gen_go    = r_go;
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign err       = r_err;
  assign done      = r_done;
  assign count     = r_count;

endmodule

// File: tb/tb_primogen_buf.sv
// Testbench for primogen_buf: two DUTs (LIMIT=0 and LIMIT=5), each driven by
// a behavioural primogen model; expected primes are queued by the stimulus
// and checked by independent output monitors.
module tb_primogen_buf;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst0, rst1, en0, en1, ord0, ord1, ign0;
  int unsigned errat0;
  logic go0, go1, val0, val1, full0, full1, err0, err1, done0, done1;
  logic rdy0, rdy1, gerr0, gerr1;
  logic [W-1:0] data0, data1, res0, res1, e0, e1;
  logic [15:0] cnt0, cnt1;
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int unsigned go_cnt0, go_cnt1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] prime_at(input int unsigned n);
    case (n)
      0: return 16'd1;   1: return 16'd2;   2: return 16'd3;   3: return 16'd5;
      4: return 16'd7;   5: return 16'd11;  6: return 16'd13;  7: return 16'd17;
      8: return 16'd19;  9: return 16'd23;  10: return 16'd29; 11: return 16'd31;
      12: return 16'd37; 13: return 16'd41; 14: return 16'd43; 15: return 16'd47;
      default: return 16'd0;
    endcase
  endfunction

  // Behavioural primogen: ready=1/res=1 after reset; a go while ready drops
  // ready, and LAT+1 cycles later the next prime appears with ready=1.
  for (genvar g = 0; g < 2; g++) begin : g_gen
    logic mrst, mgo, mign, ready, error;
    logic [W-1:0] res;
    int unsigned merr_at, idx, busy;
    assign mrst    = (g == 0) ? rst0 : rst1;
    assign mgo     = (g == 0) ? go0 : go1;
    assign mign    = (g == 0) ? ign0 : 1'b0;
    assign merr_at = (g == 0) ? errat0 : 0;
    always @(posedge clk or negedge mrst) begin
      if (!mrst) begin
        ready <= 1'b1; error <= 1'b0; res <= 16'd1; idx <= 0; busy <= 0;
      end else if (ready) begin
        if (mgo && !mign) begin
          ready <= 1'b0; error <= 1'b0; busy <= LAT;
        end
      end else if (busy != 0) begin
        busy <= busy - 1;
      end else begin
        idx   <= idx + 1;
        res   <= prime_at(idx + 1);
        ready <= 1'b1;
        error <= (merr_at != 0) && (idx + 1 == merr_at);
      end
    end
  end

  assign rdy0 = g_gen[0].ready; assign gerr0 = g_gen[0].error; assign res0 = g_gen[0].res;
  assign rdy1 = g_gen[1].ready; assign gerr1 = g_gen[1].error; assign res1 = g_gen[1].res;

  primogen_buf #(.WIDTH(W), .DEPTH(4), .LIMIT(0), .TIMEOUT(64)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .gen_go(go0), .gen_ready(rdy0),
    .gen_error(gerr0), .gen_res(res0), .out_valid(val0), .out_ready(ord0),
    .out_data(data0), .full(full0), .err(err0), .done(done0), .count(cnt0));

  primogen_buf #(.WIDTH(W), .DEPTH(4), .LIMIT(5), .TIMEOUT(64)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .gen_go(go1), .gen_ready(rdy1),
    .gen_error(gerr1), .gen_res(res1), .out_valid(val1), .out_ready(ord1),
    .out_data(data1), .full(full1), .err(err1), .done(done1), .count(cnt1));

  always @(negedge clk or negedge rst0)
    if (!rst0) go_cnt0 <= 0; else if (go0) go_cnt0 <= go_cnt0 + 1;
  always @(negedge clk or negedge rst1)
    if (!rst1) go_cnt1 <= 0; else if (go1) go_cnt1 <= go_cnt1 + 1;

  // Output monitors: every accepted beat must match the next queued prime.
  always @(negedge clk) begin
    if (rst0 && val0 && ord0) begin
      checks++;
      if (exp0.size() == 0) begin
        failures++; $display("FAIL dut0_unexpected_beat actual=%0d expected=none", data0);
      end else begin
        e0 = exp0.pop_front();
        if (data0 !== e0) begin
          failures++; $display("FAIL dut0_data actual=%0d expected=%0d", data0, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst1 && val1 && ord1) begin
      checks++;
      if (exp1.size() == 0) begin
        failures++; $display("FAIL dut1_unexpected_beat actual=%0d expected=none", data1);
      end else begin
        e1 = exp1.pop_front();
        if (data1 !== e1) begin
          failures++; $display("FAIL dut1_data actual=%0d expected=%0d", data1, e1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++; $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int which, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (which == 0) exp0.push_back(prime_at(i)); else exp1.push_back(prime_at(i));
    end
  endtask

  task automatic wait_drained(input int which, input string name);
    int unsigned t = 0;
    while (((which == 0) ? exp0.size() : exp1.size()) != 0 && t < 1000) begin
      @(posedge clk); t++;
    end
    check(name, (which == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  // Drop en0 once the n-th go pulse of dut0 has been seen.
  task automatic cut_en0(input int unsigned n, input string name);
    int unsigned t = 0;
    while (go_cnt0 < n && t < 2000) begin @(posedge clk); t++; end
    #1 en0 = 1'b0;
    check(name, go_cnt0, n);
  endtask

  task automatic reset0();
    rst0 = 1'b0;
    exp0.delete();
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned cyc;
    rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
    ord0 = 1'b0; ord1 = 1'b0; ign0 = 1'b0; errat0 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gen_go", go0, 0);
    check("rst_out_valid", val0, 0);
    check("rst_out_data", data0, 0);
    check("rst_full", full0, 0);
    check("rst_err", err0, 0);
    check("rst_done", done0, 0);
    check("rst_count", cnt0, 0);

    // LIMIT=5: exactly 1,2,3,5,7 then done, no sixth go.
    en1 = 1'b1; ord1 = 1'b1;
    push_exp(1, 5);
    rst1 = 1'b1;
    n = 0;
    while (!done1 && n < 2000) begin @(posedge clk); n++; end
    check("lim_done", done1, 1);
    repeat (40) @(posedge clk);
    #1;
    check("lim_count", cnt1, 5);
    check("lim_go_pulses", go_cnt1, 4);
    check("lim_err", err1, 0);
    wait_drained(1, "lim_drain");

    // Free-running sequence 1..37.
    en0 = 1'b1; ord0 = 1'b1;
    reset0();
    push_exp(0, 13);
    cut_en0(12, "seq_go_reach");
    wait_drained(0, "seq_drain");
    repeat (20) @(posedge clk);
    #1;
    check("seq_err", err0, 0);
    check("seq_go_pulses", go_cnt0, 12);
    check("seq_count", cnt0, 13);

    // Back-pressure: FIFO fills with 1,2,3,5 after 3 go pulses.
    en0 = 1'b1; ord0 = 1'b0;
    reset0();
    repeat (100) @(posedge clk);
    #1;
    check("bp_full", full0, 1);
    check("bp_go_pulses", go_cnt0, 3);
    check("bp_count", cnt0, 4);
    check("bp_head", data0, 1);
    push_exp(0, 6);
    ord0 = 1'b1;
    cut_en0(5, "bp_go_resume");
    wait_drained(0, "bp_drain");
    repeat (20) @(posedge clk);
    #1;
    check("bp_go_final", go_cnt0, 5);
    check("bp_count_final", cnt0, 6);

    // Generator error on the 5th prime.
    errat0 = 4; en0 = 1'b1; ord0 = 1'b1;
    reset0();
    push_exp(0, 4);
    n = 0;
    while (!err0 && n < 1000) begin @(posedge clk); n++; end
    check("gerr_err", err0, 1);
    repeat (50) @(posedge clk);
    #1;
    check("gerr_sticky", err0, 1);
    check("gerr_go_pulses", go_cnt0, 4);
    check("gerr_count", cnt0, 4);
    check("gerr_go_low", go0, 0);
    wait_drained(0, "gerr_drain");
    errat0 = 0;

    // Generator ignores go: timeout after 64 waiting cycles.
    ign0 = 1'b1; en0 = 1'b1; ord0 = 1'b1;
    reset0();
    push_exp(0, 1);
    n = 0;
    while (!go0 && n < 500) begin @(negedge clk); n++; end
    check("tmo_go_seen", go0, 1);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (err0) break;
      cyc++;
    end
    check("tmo_cycles", cyc, 64);
    check("tmo_err", err0, 1);
    repeat (10) @(posedge clk);
    #1;
    check("tmo_go_pulses", go_cnt0, 1);
    wait_drained(0, "tmo_drain");
    ign0 = 1'b0;

    // Asynchronous reset while waiting in S_WDONE.
    en0 = 1'b1; ord0 = 1'b0;
    reset0();
    n = 0;
    while (rdy0 && n < 500) begin @(negedge clk); n++; end
    check("arst_ready_fell", rdy0, 0);
    @(posedge clk);
    #2 rst0 = 1'b0;
    #1;
    check("arst_gen_go", go0, 0);
    check("arst_out_valid", val0, 0);
    check("arst_out_data", data0, 0);
    check("arst_full", full0, 0);
    check("arst_err", err0, 0);
    check("arst_done", done0, 0);
    check("arst_count", cnt0, 0);
    exp0.delete();
    en0 = 1'b0; ord0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
    @(negedge clk);
    check("arst_empty_after", val0, 0);
    push_exp(0, 1);
    wait_drained(0, "arst_first_push");
    repeat (20) @(posedge clk);
    #1;
    check("arst_count_after", cnt0, 1);
    check("arst_go_after", go_cnt0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
